// File: rtl/frame_seq_pkg.sv
// Shared types for the frame sequencer: state encoding and memory direction constants.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_GRAY    = 3'd2,
    S_FILTER  = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/frame_sequencer_if.sv
// Control/status bundle between the frame sequencer (master) and the pipeline blocks (slave).
interface frame_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             continuous;
  logic             RWM_1_done;
  logic             RWM_2_done;
  logic             GS_done;
  logic             camera_enable;
  logic             RWM_1_enable;
  logic             RWM_2_enable;
  logic             GS_enable;
  logic             filter_enable;
  logic             rw_1;
  logic             rw_2;
  logic             busy;
  logic             frame_done;
  logic [CNT_W-1:0] frame_count;
  logic             error;

  modport master (
    input  start, abort, continuous, RWM_1_done, RWM_2_done, GS_done,
    output camera_enable, RWM_1_enable, RWM_2_enable, GS_enable, filter_enable,
           rw_1, rw_2, busy, frame_done, frame_count, error
  );

  modport slave (
    output start, abort, continuous, RWM_1_done, RWM_2_done, GS_done,
    input  camera_enable, RWM_1_enable, RWM_2_enable, GS_enable, filter_enable,
           rw_1, rw_2, busy, frame_done, frame_count, error
  );
endinterface

// File: rtl/frame_sequencer_phase_timer.sv
// Loadable down-counter; expired is high once the count has run down to zero.
module phase_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/frame_sequencer.sv
// Moore phase sequencer: CAPTURE -> GRAY -> FILTER -> DONE with done blanking, abort,
// continuous mode and frame counter. Define FRAME_SEQ_WATCHDOG_EN for the per-phase watchdog.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input logic               clk,
  input logic               rst,
  frame_sequencer_if.master bus
);
  state_t           state, nxt;
  logic             first, gs_seen, r2_seen, gs_ok, r2_ok, expired;
  logic [CNT_W-1:0] count;

  // first is high in the opening cycle of each state; dones are blanked there
  assign gs_ok = gs_seen | (!first & bus.GS_done);
  assign r2_ok = r2_seen | (!first & bus.RWM_2_done);

`ifdef FRAME_SEQ_WATCHDOG_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic active;
  assign active = (state == S_CAPTURE) || (state == S_GRAY) || (state == S_FILTER);

  phase_timer #(.W(TMO_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (nxt != state),
    .en       (active),
    .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
    .expired  (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (bus.start) nxt = S_CAPTURE;
      S_CAPTURE: if (!first && bus.RWM_1_done) nxt = S_GRAY;
                 else if (expired)             nxt = S_ERROR;
      S_GRAY:    if (gs_ok && r2_ok)           nxt = S_FILTER;
                 else if (expired)             nxt = S_ERROR;
      S_FILTER:  if (!first && bus.RWM_2_done) nxt = S_DONE;
                 else if (expired)             nxt = S_ERROR;
      S_DONE:    nxt = bus.continuous ? S_CAPTURE : S_IDLE;
      S_ERROR:   if (bus.start) nxt = S_CAPTURE;
      default:   nxt = S_IDLE;
    endcase
    if (bus.abort) nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      first   <= 1'b1;
      gs_seen <= 1'b0;
      r2_seen <= 1'b0;
      count   <= '0;
    end else begin
      state <= nxt;
      first <= (nxt != state);
      if (nxt != state) begin
        gs_seen <= 1'b0;
        r2_seen <= 1'b0;
      end else if (state == S_GRAY && !first) begin
        gs_seen <= gs_seen | bus.GS_done;
        r2_seen <= r2_seen | bus.RWM_2_done;
      end
      // DONE is committed once entered, so it counts even if aborted
      if (state == S_DONE) count <= count + 1'b1;
    end
  end

  always_comb begin
    bus.camera_enable = 1'b0;
    bus.RWM_1_enable  = 1'b0;
    bus.RWM_2_enable  = 1'b0;
    bus.GS_enable     = 1'b0;
    bus.filter_enable = 1'b0;
    bus.rw_1          = RW_READ;
    bus.rw_2          = RW_READ;
    bus.busy          = (state != S_IDLE) && (state != S_ERROR);
    bus.frame_done    = (state == S_DONE);
`ifdef FRAME_SEQ_WATCHDOG_EN
    bus.error         = (state == S_ERROR);
`else
    bus.error         = 1'b0;
`endif
    case (state)
      S_CAPTURE: begin
        bus.camera_enable = 1'b1;
        bus.RWM_1_enable  = 1'b1;
        bus.rw_1          = RW_WRITE;
      end
      S_GRAY: begin
        bus.RWM_1_enable  = 1'b1;
        bus.GS_enable     = 1'b1;
        bus.RWM_2_enable  = 1'b1;
        bus.rw_2          = RW_WRITE;
      end
      S_FILTER: begin
        bus.RWM_2_enable  = 1'b1;
        bus.filter_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.frame_count = count;
endmodule

// File: tb/tb_frame_sequencer.sv
// Scenario bench for frame_sequencer; frame_done pulses are checked against a scoreboard queue.
module tb_frame_sequencer;
  localparam int P_IDLE = 0, P_CAP = 1, P_GRAY = 2, P_FILT = 3, P_DONE = 4, P_ERR = 5, P_BAD = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  frame_sequencer_if #(.CNT_W(16)) bus ();
  frame_sequencer_if #(.CNT_W(2))  bus2 ();

  assign bus2.start      = bus.start;
  assign bus2.abort      = bus.abort;
  assign bus2.continuous = bus.continuous;
  assign bus2.RWM_1_done = bus.RWM_1_done;
  assign bus2.RWM_2_done = bus.RWM_2_done;
  assign bus2.GS_done    = bus.GS_done;

  frame_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  frame_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Phase implied by the full output pattern; P_BAD if it matches no row of the phase table.
  function automatic int phase();
    logic [9:0] p;
    p = {bus.camera_enable, bus.RWM_1_enable, bus.rw_1, bus.GS_enable, bus.RWM_2_enable,
         bus.rw_2, bus.filter_enable, bus.busy, bus.frame_done, bus.error};
    case (p)
      10'b0000000000: return P_IDLE;
      10'b1110000100: return P_CAP;
      10'b0101110100: return P_GRAY;
      10'b0000101100: return P_FILT;
      10'b0000000110: return P_DONE;
      10'b0000000001: return P_ERR;
      default:        return P_BAD;
    endcase
  endfunction

  task automatic set_in(input logic st, ab, co, r1, r2, gs);
    bus.start = st; bus.abort = ab; bus.continuous = co;
    bus.RWM_1_done = r1; bus.RWM_2_done = r2; bus.GS_done = gs;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  // Scoreboard: each frame_done pulse pops the frame_count expected while in DONE.
  always @(negedge clk) begin
    if (!rst && bus.frame_done) begin
      n_checks++;
      if (exp_q.size() == 0)
        $display("FAIL sb_unexpected_frame_done count=%0d", bus.frame_count);
      else begin
        int e;
        e = exp_q.pop_front();
        if (bus.frame_count !== 16'(e))
          $display("FAIL sb_frame_count got=%0d exp=%0d", bus.frame_count, e);
        else n_pass++;
      end
    end
  end

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (phase() !== P_IDLE) $display("FAIL reset_outputs got=%0d exp=%0d", phase(), P_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.frame_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", bus.frame_count);
    else n_pass++;
  endtask

  task automatic test_single_frame();
    int e;
    exp_q.push_back(exp_cnt);
    exp_cnt++;
    for (int c = 0; c <= 45; c++) begin
      set_in(c == 0, 0, 0, c == 10, (c == 25) || (c == 40), c == 20);
      step();
      e = (c < 10) ? P_CAP : (c < 25) ? P_GRAY : (c < 40) ? P_FILT : (c == 40) ? P_DONE : P_IDLE;
      n_checks++;
      if (phase() !== e) $display("FAIL single_frame c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.frame_count !== 16'(exp_cnt))
      $display("FAIL single_count got=%0d exp=%0d", bus.frame_count, exp_cnt);
    else n_pass++;
  endtask

  // r=0: RWM_2 then GS; r=1: both together; r=2: both in the blanked first GRAY cycle, then together.
  task automatic test_gray_order();
    int e, g;
    logic r2d, gsd;
    for (int r = 0; r < 3; r++) begin
      g = (r == 0) ? 8 : (r == 1) ? 5 : 6;
      exp_q.push_back(exp_cnt);
      exp_cnt++;
      for (int c = 0; c <= g + 6; c++) begin
        gsd = (c == g) || (r == 2 && c == 3);
        r2d = (r != 2 && c == 5) || (r == 2 && c == 3) || (c == g) || (c == g + 4);
        set_in(c == 0, 0, 0, c == 2, r2d, gsd);
        step();
        e = (c < 2) ? P_CAP : (c < g) ? P_GRAY : (c < g + 4) ? P_FILT : (c == g + 4) ? P_DONE : P_IDLE;
        n_checks++;
        if (phase() !== e) $display("FAIL gray_order r=%0d c=%0d got=%0d exp=%0d", r, c, phase(), e);
        else n_pass++;
      end
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_stale_done();
    int e;
    exp_q.push_back(exp_cnt);
    exp_cnt++;
    for (int c = 0; c <= 9; c++) begin
      set_in(c == 0, 0, 0, c >= 2, (c >= 4) && (c <= 6), c == 4);
      step();
      e = (c < 2) ? P_CAP : (c < 4) ? P_GRAY : (c < 6) ? P_FILT : (c == 6) ? P_DONE : P_IDLE;
      n_checks++;
      if (phase() !== e) $display("FAIL stale_done c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    int e;
    for (int c = 0; c <= 6; c++) begin
      set_in(c == 0, c == 5, 0, c == 2, 0, c == 5);
      step();
      e = (c < 2) ? P_CAP : (c < 5) ? P_GRAY : P_IDLE;
      n_checks++;
      if (phase() !== e) $display("FAIL abort_gray c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
    set_in(1, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (phase() !== P_IDLE) $display("FAIL abort_vs_start got=%0d exp=%0d", phase(), P_IDLE);
    else n_pass++;
    n_checks++;
    if (bus.frame_count !== 16'(exp_cnt))
      $display("FAIL abort_count got=%0d exp=%0d", bus.frame_count, exp_cnt);
    else n_pass++;
    // abort during DONE with continuous set: frame still counts, returns to IDLE
    exp_q.push_back(exp_cnt);
    exp_cnt++;
    for (int c = 0; c <= 8; c++) begin
      set_in(c == 0, c == 7, 1, 1, 1, 1);
      step();
      e = (c < 2) ? P_CAP : (c < 4) ? P_GRAY : (c < 6) ? P_FILT : (c == 6) ? P_DONE : P_IDLE;
      n_checks++;
      if (phase() !== e) $display("FAIL abort_done c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (bus.frame_count !== 16'(exp_cnt))
      $display("FAIL abort_done_count got=%0d exp=%0d", bus.frame_count, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    int e;
`ifdef FRAME_SEQ_WATCHDOG_EN
    for (int c = 0; c <= 18; c++) begin
      set_in(c == 0, 0, 0, 0, 0, 0);
      step();
      e = (c < 16) ? P_CAP : P_ERR;
      n_checks++;
      if (phase() !== e) $display("FAIL watchdog c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
    set_in(1, 0, 0, 0, 0, 0);
    step();
    n_checks++;
    if (phase() !== P_CAP || bus.error !== 1'b0)
      $display("FAIL watchdog_restart got=%0d err=%b exp=%0d", phase(), bus.error, P_CAP);
    else n_pass++;
`else
    for (int c = 0; c <= 40; c++) begin
      set_in(c == 0, 0, 0, 0, 0, 0);
      step();
      e = P_CAP;
      n_checks++;
      if (phase() !== e) $display("FAIL no_watchdog c=%0d got=%0d exp=%0d", c, phase(), e);
      else n_pass++;
    end
`endif
    set_in(0, 1, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    n_checks++;
    if (phase() !== P_IDLE) $display("FAIL watchdog_abort got=%0d exp=%0d", phase(), P_IDLE);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int c = 0; c <= 4; c++) begin
      set_in(c == 0, 0, 0, c == 2, 0, 0);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (phase() !== P_IDLE || bus.frame_count !== 16'd0)
      $display("FAIL async_reset got=%0d count=%0d exp=%0d count=0", phase(), bus.frame_count, P_IDLE);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_continuous(input int n);
    int e, off;
    do_reset();
    for (int k = 0; k < n; k++) exp_q.push_back(k);
    for (int c = 0; c <= 7 * n + 1; c++) begin
      set_in(c == 0, 0, c < 7 * n, 1, 1, 1);
      step();
      off = c % 7;
      e = (c >= 7 * n) ? P_IDLE : (off < 2) ? P_CAP : (off < 4) ? P_GRAY : (off < 6) ? P_FILT : P_DONE;
      n_checks++;
      if (phase() !== e) $display("FAIL continuous n=%0d c=%0d got=%0d exp=%0d", n, c, phase(), e);
      else n_pass++;
    end
    set_in(0, 0, 0, 0, 0, 0);
    exp_cnt = n;
    n_checks++;
    if (bus.frame_count !== 16'(n))
      $display("FAIL continuous_count got=%0d exp=%0d", bus.frame_count, n);
    else n_pass++;
    n_checks++;
    if (bus2.frame_count !== 2'(n))
      $display("FAIL continuous_wrap got=%0d exp=%0d", bus2.frame_count, n % 4);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gray_order();
    test_stale_done();
    test_abort();
    test_watchdog();
    test_async_reset();
    test_continuous(3);
    test_continuous(5);
    repeat (2) step();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_missing_frames left=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Top-level phase sequencer for the keypoint pipeline. It drives the single-frame flow: camera capture into RWM_1, grayscale conversion from RWM_1 through the Grayscaler into RWM_2, then a read-out of RWM_2 into filter5x5/keypoints. It replaces the ad-hoc start/enable wiring with an explicit Moore FSM that adds done-handshake latching, abort, continuous mode, a frame counter and an optional per-phase watchdog.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum cycles per phase before the watchdog fires. Used only with the watchdog compiled in.
- `CNT_W`, default 16: width of `frame_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a frame. Sampled only in IDLE and ERROR.
- `abort` in 1: forces a return to IDLE from any state.
- `continuous` in 1: while high, DONE returns to CAPTURE instead of IDLE.
- `RWM_1_done`, `RWM_2_done`, `GS_done` in 1 each: level done flags from the memories and the Grayscaler.
- `camera_enable`, `RWM_1_enable`, `RWM_2_enable`, `GS_enable`, `filter_enable` out 1 each: phase enables.
- `rw_1`, `rw_2` out 1 each: memory direction, 1 = write, 0 = read.
- `busy` out 1: high in every state except IDLE and ERROR.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `frame_count` out CNT_W: number of completed frames. Wraps modulo 2^CNT_W.
- `error` out 1: watchdog fired. Tied to 0 when the watchdog is compiled out.

## Operation
- States: IDLE, CAPTURE, GRAY, FILTER, DONE, ERROR. State is registered and outputs are decoded from state only.
- IDLE: all enables are 0. `start` moves the FSM to CAPTURE.
- CAPTURE:
  - Outputs: `camera_enable`=1, `RWM_1_enable`=1, `rw_1`=1.
  - `RWM_1_done` moves the FSM to GRAY.
- GRAY:
  - Outputs: `RWM_1_enable`=1, `rw_1`=0, `GS_enable`=1, `RWM_2_enable`=1, `rw_2`=1.
  - `GS_done` and `RWM_2_done` are each latched into sticky flags.
  - The FSM moves to FILTER on the cycle both flags (or the raw inputs) are set. Arrival order is free; simultaneous arrival is allowed.
- FILTER:
  - Outputs: `RWM_2_enable`=1, `rw_2`=0, `filter_enable`=1.
  - `RWM_2_done` moves the FSM to DONE.
- DONE:
  - Held for exactly one cycle.
  - `frame_done`=1 and `frame_count` increments.
  - Next state is CAPTURE if `continuous`=1, otherwise IDLE.
- ERROR: all enables are 0 and `error`=1. `start` clears `error` and moves the FSM to CAPTURE.
- Done blanking:
  - All done inputs are ignored in the first cycle of every phase. This prevents a stale level done from the previous phase (e.g. `RWM_2_done` still high entering FILTER) from skipping a phase.
  - Done inputs that do not belong to the current phase are ignored.
- `abort` has priority over every other transition, including `start` and done inputs in the same cycle. Next state is IDLE.
  - Sticky flags are cleared and `frame_count` is unchanged.
  - Abort in DONE still counts the frame: the DONE cycle is already committed.
- Sticky flags clear on every state change.

## Timing
- Reset values:
  - State = IDLE.
  - All enables, `rw_1`, `rw_2`, `busy`, `frame_done` and `error` = 0.
  - `frame_count` = 0.
- Latency:
  - `start` sampled at edge k: CAPTURE outputs are valid after edge k.
  - Done sampled at edge k: next-phase outputs are valid after edge k.
  - Minimum phase length is 2 cycles, because of done blanking.
- `frame_done` rises after the edge that enters DONE and falls one cycle later. `frame_count` updates on the same edge that leaves DONE.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous), with no partial-frame count.

## Configuration
- `FRAME_SEQ_WATCHDOG_EN` defined:
  - A phase timer resets on every state entry and counts while in CAPTURE, GRAY or FILTER.
  - When the timer reaches `TIMEOUT_CYCLES`-1 without the exit condition, the next state is ERROR.
  - Abort still takes priority over the timeout.
- `FRAME_SEQ_WATCHDOG_EN` undefined:
  - No timer logic.
  - ERROR is unreachable.
  - `error` is constant 0.

## Structure
- Shared package `frame_seq_pkg`:
  - State enum encoding (IDLE=0, CAPTURE=1, GRAY=2, FILTER=3, DONE=4, ERROR=5).
  - `RW_WRITE`/`RW_READ` constants.
- One sub-module, `phase_timer`: loadable down-counter with an expiry flag. It is instantiated only under `FRAME_SEQ_WATCHDOG_EN`.

## Test plan
- Single frame:
  - Stimulus: start, then `RWM_1_done` at cycle 10, `GS_done` at 20, `RWM_2_done` at 25, `RWM_2_done` again at 40.
  - Response: states run CAPTURE→GRAY→FILTER→DONE→IDLE; `frame_done` pulses once; `frame_count`=1; enables match the phase table every cycle.
- GRAY ordering:
  - Stimulus: `RWM_2_done` before `GS_done`, then a run with both in the same cycle.
  - Response: GRAY exits only once both are seen, exactly one cycle after the later one.
- Stale done:
  - Stimulus: hold `RWM_2_done`=1 from GRAY into FILTER.
  - Response: FILTER lasts at least 2 cycles and no phase is skipped.
- Continuous mode:
  - Stimulus: `continuous`=1 for 3 frames; repeat with `CNT_W`=2 and 5 frames.
  - Response: `frame_count`=3 in the first run, wraps to 1 in the second; no IDLE cycle between frames.
- Abort:
  - Stimulus: abort asserted in GRAY together with `GS_done`; separately, abort and start in the same cycle in IDLE.
  - Response: IDLE next cycle in both cases; `frame_count` unchanged.
- Watchdog:
  - Stimulus: `TIMEOUT_CYCLES`=16, with no `RWM_1_done` after start.
  - Response: ERROR entered 16 cycles after CAPTURE entry; `error`=1; a subsequent start reaches CAPTURE with `error`=0.
  - Without the macro, the FSM stays in CAPTURE indefinitely.
